// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
package branch_resolve_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_RECOVER  = 2'd2
  } state_e;

  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam int         INSN_SIZE = 4;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/decode-side signal bundle of the branch resolution controller.
interface branch_resolve_ctrl_if #(
  parameter int PC_W   = 64,
  parameter int N_BITS = 2
);
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              id_stall;
  logic              id_is_branch;
  logic              id_zero_flag;
  logic [PC_W-1:0]   id_target;
  logic              upd_en;
  logic [N_BITS-1:0] upd_idx;
  logic              upd_taken;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush_if;
  logic              busy;

  modport master (
    output if_valid, if_pc, pred_taken, pred_target,
           id_stall, id_is_branch, id_zero_flag, id_target,
    input  upd_en, upd_idx, upd_taken, redirect_valid, redirect_pc, flush_if, busy
  );

  modport slave (
    input  if_valid, if_pc, pred_taken, pred_target,
           id_stall, id_is_branch, id_zero_flag, id_target,
    output upd_en, upd_idx, upd_taken, redirect_valid, redirect_pc, flush_if, busy
  );
endinterface

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for branch statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                  count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves branch predictions in ID, redirects fetch and trains the predictor.
// Optional statistics counters are enabled with macro BRANCH_STATS_EN.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int PC_W   = 64,
  parameter int N_REG  = 4,
  parameter int STAT_W = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  branch_resolve_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispredicts
`endif
);

  localparam int N_BITS = (N_REG > 1) ? $clog2(N_REG) : 1;

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  state_e            state, state_nxt;
  logic              trk_valid, trk_pred_taken;
  logic [PC_W-1:0]   trk_pc, trk_target;
  logic [PC_W-1:0]   seq_pc, correct_pc;
  logic              resolve, mispredict, redirect_req, upd_req;
  logic              upd_en_q, upd_taken_q;
  logic [N_BITS-1:0] upd_idx_q;
  logic [PC_W-1:0]   redirect_pc_q;
  logic              in_redirect;

  assign seq_pc      = trk_pc + PC_W'(INSN_SIZE);
  assign in_redirect = (state == ST_REDIRECT);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mispredict = 1'b0;
    correct_pc = seq_pc;
    if (bus.id_is_branch) begin
      if (bus.id_zero_flag && (!trk_pred_taken || (trk_target != bus.id_target))) begin
        mispredict = 1'b1;
        correct_pc = bus.id_target;
      end else if (!bus.id_zero_flag && trk_pred_taken) begin
        mispredict = 1'b1;
      end
    end else if (trk_pred_taken) begin
      mispredict = 1'b1;  // aliased entry predicted a non-branch as taken
    end
  end

  assign resolve      = trk_valid && !bus.id_stall && (state == ST_IDLE);
  assign redirect_req = resolve && mispredict;
  assign upd_req      = resolve && bus.id_is_branch;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (redirect_req) state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (!bus.id_stall) state_nxt = ST_RECOVER;
      ST_RECOVER:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // The slot captured while flushing is the wrong-path instruction, so it
  // enters ID invalid and RECOVER never resolves it.
  // NOTE: the tracking datapath is reset too, not just its valid bit, so a reset leaves no stale PC visible.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      trk_valid      <= 1'b0;
      trk_pc         <= '0;
      trk_pred_taken <= 1'b0;
      trk_target     <= '0;
    end else if (!bus.id_stall) begin
      trk_valid      <= bus.if_valid && !in_redirect;
      trk_pc         <= bus.if_pc;
      trk_pred_taken <= bus.pred_taken;
      trk_target     <= bus.pred_target;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en_q      <= 1'b0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      upd_en_q <= upd_req;
      if (upd_req) begin
        upd_idx_q   <= trk_pc[2*N_BITS-1:N_BITS];
        upd_taken_q <= bus.id_zero_flag;
      end
      if (redirect_req) redirect_pc_q <= correct_pc;
    end
  end

  assign bus.upd_en         = upd_en_q;
  assign bus.upd_idx        = upd_idx_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.redirect_valid = in_redirect;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if       = in_redirect;
  assign bus.busy           = (state != ST_IDLE);

`ifdef BRANCH_STATS_EN
  sat_counter #(.W(STAT_W)) u_stat_branches (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (upd_req),
    .clr    (1'b0),
    .count  (stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_mispredicts (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (redirect_req),
    .clr    (1'b0),
    .count  (stat_mispredicts)
  );
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a per-cycle reference model.
module tb_branch_resolve_ctrl;

  localparam int PC_W     = 64;
  localparam int N_REG    = 4;
  localparam int STAT_W   = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic cmp_en = 1'b1;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.PC_W(PC_W), .N_BITS(2)) bus ();

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_ctrl #(.PC_W(PC_W), .N_REG(N_REG), .STAT_W(STAT_W)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .bus              (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_REDIRECT, M_RECOVER} mmode_e;
  mmode_e      m_mode;
  logic        m_id_valid, m_id_pt;
  logic [63:0] m_id_pc, m_id_ptgt;
  logic        e_upd_en, e_upd_taken;
  logic [1:0]  e_upd_idx;
  logic [63:0] e_redirect_pc;
  int          e_stat_br, e_stat_mp;

  task automatic model_reset();
    m_mode = M_IDLE; m_id_valid = 0; m_id_pt = 0; m_id_pc = 0; m_id_ptgt = 0;
    e_upd_en = 0; e_upd_taken = 0; e_upd_idx = 0; e_redirect_pc = 0;
    e_stat_br = 0; e_stat_mp = 0;
  endtask

  // Called right after a rising edge, with the inputs that were present at it.
  task automatic model_step();
    logic   resolving, actual_taken, wrong;
    logic [63:0] fix;
    mmode_e nxt;
    resolving    = m_id_valid && !bus.id_stall && (m_mode == M_IDLE);
    actual_taken = bus.id_is_branch && bus.id_zero_flag;
    wrong        = (actual_taken != m_id_pt) || (actual_taken && (m_id_ptgt != bus.id_target));
    fix          = actual_taken ? bus.id_target : m_id_pc + 64'd4;
    e_upd_en     = resolving && bus.id_is_branch;
    if (e_upd_en) begin
      e_upd_idx   = 2'((m_id_pc / 64'd4) % 64'd4);
      e_upd_taken = bus.id_zero_flag;
      if (e_stat_br < STAT_MAX) e_stat_br++;
    end
    nxt = m_mode;
    if (resolving && wrong) begin
      e_redirect_pc = fix;
      if (e_stat_mp < STAT_MAX) e_stat_mp++;
      nxt = M_REDIRECT;
    end
    if (m_mode == M_REDIRECT && !bus.id_stall) nxt = M_RECOVER;
    if (m_mode == M_RECOVER) nxt = M_IDLE;
    if (!bus.id_stall) begin
      m_id_valid = bus.if_valid && (m_mode != M_REDIRECT);
      m_id_pc    = bus.if_pc;
      m_id_pt    = bus.pred_taken;
      m_id_ptgt  = bus.pred_target;
    end
    m_mode = nxt;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("upd_en",         bus.upd_en,         e_upd_en);
      check("upd_idx",        bus.upd_idx,        e_upd_idx);
      check("upd_taken",      bus.upd_taken,      e_upd_taken);
      check("redirect_valid", bus.redirect_valid, m_mode == M_REDIRECT);
      check("redirect_pc",    bus.redirect_pc,    e_redirect_pc);
      check("flush_if",       bus.flush_if,       m_mode == M_REDIRECT);
      check("busy",           bus.busy,           m_mode != M_IDLE);
`ifdef BRANCH_STATS_EN
      check("stat_branches",    stat_branches,    e_stat_br);
      check("stat_mispredicts", stat_mispredicts, e_stat_mp);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic v, input logic [63:0] pc, input logic pt, input logic [63:0] ptgt,
                       input logic st, input logic br, input logic z, input logic [63:0] tgt);
    bus.if_valid = v; bus.if_pc = pc; bus.pred_taken = pt; bus.pred_target = ptgt;
    bus.id_stall = st; bus.id_is_branch = br; bus.id_zero_flag = z; bus.id_target = tgt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int rv_cnt, ue_cnt;

  initial begin
    model_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_busy",           bus.busy,           0);
    check("rst_upd_en",         bus.upd_en,         0);
    check("rst_redirect_pc",    bus.redirect_pc,    0);
    @(negedge clk); #2 arst_n = 1'b1;

    // taken branch predicted not-taken
    cycle(1, 64'h100, 0, 0, 0, 0, 0, 0);
    cycle(1, 64'h104, 0, 0, 0, 1, 1, 64'h140);
    check("nt_mis_rv",    bus.redirect_valid, 1);
    check("nt_mis_pc",    bus.redirect_pc,    64'h140);
    check("nt_mis_flush", bus.flush_if,       1);
    check("nt_mis_upd",   bus.upd_en,         1);
    check("nt_mis_idx",   bus.upd_idx,        0);
    check("nt_mis_tkn",   bus.upd_taken,      1);
    cycle(1, 64'h108, 1, 64'h300, 0, 1, 1, 64'h999);   // wrong path, flushed
    check("recover_busy", bus.busy, 1);
    check("recover_upd",  bus.upd_en, 0);
    cycle(1, 64'h140, 0, 0, 0, 0, 0, 0);               // squashed slot would alias
    check("recover_rv",   bus.redirect_valid, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);                     // N+3 resolution
    check("n3_upd",  bus.upd_en, 1);
    check("n3_rv",   bus.redirect_valid, 0);
    check("n3_busy", bus.busy, 0);

    // not-taken branch predicted taken
    cycle(1, 64'h104, 1, 64'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 64'h200);
    check("tk_mis_pc",  bus.redirect_pc, 64'h108);
    check("tk_mis_tkn", bus.upd_taken,   0);
    check("tk_mis_idx", bus.upd_idx,     1);
    idle(); idle();

    // correct taken prediction
    cycle(1, 64'h180, 1, 64'h1c0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 64'h1c0);
    check("ok_upd",  bus.upd_en, 1);
    check("ok_rv",   bus.redirect_valid, 0);
    check("ok_busy", bus.busy, 0);
    idle();
    check("ok_upd_pulse", bus.upd_en, 0);

    // taken as predicted but to a different target
    cycle(1, 64'h10c, 1, 64'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 64'h240);
    check("tgt_mis_pc",  bus.redirect_pc, 64'h240);
    check("tgt_mis_idx", bus.upd_idx, 3);
    idle(); idle();

    // ID stalled while idle: the tracked slot holds
    cycle(1, 64'h130, 1, 64'h500, 0, 0, 0, 0);
    cycle(1, 64'h990, 0, 0, 1, 1, 0, 0);
    check("stall_no_upd", bus.upd_en, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("stall_hold_pc", bus.redirect_pc, 64'h134);
    idle(); idle();

    // mispredict with ID stalled for 3 cycles in REDIRECT
    cycle(1, 64'h120, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 64'h400);
    rv_cnt = int'(bus.redirect_valid); ue_cnt = int'(bus.upd_en);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 1, 1, 64'h400);
      rv_cnt += int'(bus.redirect_valid); ue_cnt += int'(bus.upd_en);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    rv_cnt += int'(bus.redirect_valid); ue_cnt += int'(bus.upd_en);
    check("stall_recover_busy", bus.busy, 1);
    idle();
    check("stall_idle_busy", bus.busy, 0);
    check("stall_rv_cycles", rv_cnt, 4);
    check("stall_upd_count", ue_cnt, 1);

    // aliasing non-branch predicted taken at the top of the address space
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h800, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc",  bus.redirect_pc, 0);
    check("wrap_rv",  bus.redirect_valid, 1);
    check("wrap_upd", bus.upd_en, 0);
    idle(); idle();

    // invalid fetch slot never mispredicts
    cycle(0, 64'h200, 1, 64'h900, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("inval_rv",  bus.redirect_valid, 0);
    check("inval_upd", bus.upd_en, 0);

    // reset asserted during REDIRECT
    cycle(1, 64'h100, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 64'h140);
    check("pre_rst_rv", bus.redirect_valid, 1);
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    check("arst_rv",    bus.redirect_valid, 0);
    check("arst_flush", bus.flush_if, 0);
    check("arst_busy",  bus.busy, 0);
    check("arst_upd",   bus.upd_en, 0);
    check("arst_pc",    bus.redirect_pc, 0);
    check("arst_idx",   bus.upd_idx, 0);
`ifdef BRANCH_STATS_EN
    check("arst_stat_mp", stat_mispredicts, 0);
    check("arst_stat_br", stat_branches, 0);
`endif
    @(negedge clk); #2 arst_n = 1'b1;
    idle();

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < STAT_MAX + 2; i++) begin
      cycle(1, 64'h100, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 1, 64'h140);
      idle(); idle();
    end
    check("sat_mispredicts", stat_mispredicts, STAT_MAX);
    check("sat_branches",    stat_branches,    STAT_MAX);
`endif

    idle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 64: PC and target width.
REQ-002 SHALL have parameter N_REG, default 4: number of predictor entries; N_BITS = clog2(N_REG).
REQ-003 SHALL have parameter STAT_W, default 32: statistics counter width.
REQ-004 SHALL have clk  input  1: clock, rising edge.
REQ-005 SHALL have arst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have if_valid  input  1: IF stage holds a valid instruction.
REQ-007 SHALL have if_pc  input  PC_W: PC of the instruction in IF.
REQ-008 SHALL have pred_taken  input  1 and pred_target  input  PC_W: the predictor's decision and target for if_pc.
REQ-009 SHALL have id_stall  input  1: IF/ID pipeline register frozen this cycle.
REQ-010 SHALL have id_is_branch  input  1, id_zero_flag  input  1 and id_target  input  PC_W: branch decode, resolved outcome and computed target in ID.
REQ-011 SHALL have upd_en  output  1, upd_idx  output  N_BITS and upd_taken  output  1: predictor update strobe, entry and outcome.
REQ-012 SHALL have redirect_valid  output  1 and redirect_pc  output  PC_W: PC override for fetch.
REQ-013 SHALL have flush_if  output  1: kill the instruction in IF; busy  output  1: FSM not in IDLE.

Function
REQ-014 SHALL capture {if_valid, if_pc, pred_taken, pred_target} into tracking register trk on each rising edge with id_stall=0; trk SHALL hold while id_stall=1.
REQ-015 SHALL resolve in ID when trk.valid=1 and id_stall=0 and the FSM is in IDLE.
REQ-016 Resolution cases:
- Branch, taken and mispredicted as not-taken: correct PC = id_target.
- Branch, not taken but predicted taken: correct PC = trk.pc+4.
- Branch taken, predicted taken, trk.target != id_target: correct PC = id_target.
- Non-branch predicted taken (aliasing): correct PC = trk.pc+4.
- All other cases are correct predictions.
REQ-017 SHALL, on any branch resolution, pulse upd_en for exactly 1 cycle on the next edge, with upd_idx = trk.pc[2*N_BITS-1:N_BITS] and upd_taken = id_zero_flag; a non-branch SHALL NOT produce upd_en.
REQ-018 FSM states SHALL be IDLE, REDIRECT and RECOVER.
- IDLE to REDIRECT on a mispredict, registered with redirect_pc = correct PC.
- REDIRECT to RECOVER when id_stall=0.
- RECOVER to IDLE after 1 cycle.
REQ-019 In REDIRECT, redirect_valid=1 and flush_if=1, held for as long as id_stall=1.
REQ-020 In RECOVER, trk.valid SHALL be forced to 0 and no resolution SHALL occur, so the flushed instruction is squashed.
REQ-021 Latency: mispredict in ID at cycle N gives redirect_valid at N+1; the earliest next resolution is at N+3.
REQ-022 trk.pc+4 SHALL wrap modulo 2^PC_W.
REQ-023 If if_valid=0 on capture, trk.valid=0 and that slot SHALL never mispredict.

Reset
REQ-024 On arst_n=0 all registers SHALL clear immediately: FSM=IDLE, trk.valid=0, and upd_en, redirect_valid, flush_if and busy all 0.
REQ-025 redirect_pc and upd_idx SHALL reset to 0.
REQ-026 Reset mid-REDIRECT SHALL drop redirect_valid in the same cycle, with no pending update.

Configuration
REQ-027 With macro BRANCH_STATS_EN defined, the block SHALL add outputs stat_branches and stat_mispredicts (STAT_W each) that count resolved branches and mispredicts.
REQ-028 The counters SHALL saturate at all-ones and reset to 0.
REQ-029 Without BRANCH_STATS_EN, the ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (2 bits), the BRANCH_EQ opcode constant (7'b1100011) and the instruction size constant 4.
REQ-031 Sub-module sat_counter (parameter W; inputs inc and clr) SHALL implement the statistics counters; it is instantiated only under BRANCH_STATS_EN.

Verification
REQ-032 Predicted not-taken, if_pc=0x100, branch taken, id_target=0x140: the next cycle shows redirect_valid=1, redirect_pc=0x140, flush_if=1, upd_en=1, upd_idx=0, upd_taken=1.
REQ-033 Predicted taken to 0x200, branch not taken at pc 0x104: redirect_pc=0x108, upd_taken=0, upd_idx=1.
REQ-034 Correct taken prediction with matching target: redirect_valid stays 0, upd_en=1 for 1 cycle, busy stays 0.
REQ-035 Mispredict with id_stall=1 for 3 cycles: redirect_valid held for 4 cycles, then RECOVER for 1 cycle, then IDLE; exactly 1 upd_en.
REQ-036 Non-branch predicted taken at pc 0xFFFFFFFFFFFFFFFC: redirect_pc=0, upd_en=0.
REQ-037 Assert arst_n low during REDIRECT: all outputs 0 immediately; with BRANCH_STATS_EN, counters read 0, and after 2^STAT_W mispredicts stat_mispredicts stays at all-ones.
